tern_matvec_sequencer: RTL

Controller that sequences a LANES-wide ternary multiply-accumulate slice through a full ROWS x COLS ternary matrix-vector product, y[r] = sum_k x[k]*W[r][k].
It fetches activation and weight chunks from external single-cycle-latency buffers and accumulates each row with saturation.
Each finished row result is emitted over a valid/ready stream.
It replaces the flat fully-parallel multiplier where area matters, trading throughput for one shared LANES-wide datapath.

---
 rtl/tern_matvec_sequencer_if.sv | 40 ++++
 rtl/tern_matvec_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/tern_matvec_sequencer_if.sv
// Stream/buffer bundle for the ternary mat-vec sequencer: control, buffer reads, result stream.
interface tern_matvec_sequencer_if #(
    parameter int ROWS  = 64,
    parameter int COLS  = 64,
    parameter int LANES = 8,
    parameter int ACT_W = 8,
    parameter int ACC_W = 20
);
    localparam int CH  = COLS / LANES;
    localparam int AAW = (CH > 1) ? $clog2(CH) : 1;
    localparam int WAW = (ROWS * CH > 1) ? $clog2(ROWS * CH) : 1;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                   start;
    logic                   busy;
    logic                   done;
    logic                   act_rd_en;
    logic [AAW-1:0]         act_addr;
    logic [LANES*ACT_W-1:0] act_rdata;
    logic                   w_rd_en;
    logic [WAW-1:0]         w_addr;
    logic [LANES*2-1:0]     w_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_W-1:0]       out_data;
    logic [RW-1:0]          out_row;
    logic                   sat_flag;
    logic                   code_err;

    modport slave (
        input  start, act_rdata, w_rdata, out_ready,
        output busy, done, act_rd_en, act_addr, w_rd_en, w_addr,
               out_valid, out_data, out_row, sat_flag, code_err
    );
    modport master (
        output start, act_rdata, w_rdata, out_ready,
        input  busy, done, act_rd_en, act_addr, w_rd_en, w_addr,
               out_valid, out_data, out_row, sat_flag, code_err
    );
endinterface

// File: rtl/tern_matvec_sequencer.sv
// Sequences one LANES-wide ternary MAC slice over a ROWS x COLS matrix, one chunk per cycle,
// saturating each row sum and streaming row results out over valid/ready.
module tern_matvec_sequencer #(
    parameter int ROWS  = 64,
    parameter int COLS  = 64,
    parameter int LANES = 8,
    parameter int ACT_W = 8,
    parameter int ACC_W = 20
) (
    input logic clk,
    input logic rst_n,
    tern_matvec_sequencer_if.slave bus
);
    localparam int CH    = COLS / LANES;
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int WAW   = (ROWS * CH > 1) ? $clog2(ROWS * CH) : 1;
    localparam int SUM_W = ACT_W + 2 + $clog2(LANES);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_OUT, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [RW-1:0]            r_q, r_d;
    logic [CW-1:0]            c_q, c_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     rd_vld_q, rd_first_q;
    logic                     sat_q, sat_d, err_q, err_d, row_sat_q, row_sat_d;
    logic                     issue;

    logic [LANES-1:0][ACT_W:0] prod;
    logic [LANES-1:0]          lerr;
    logic signed [SUM_W-1:0]   lsum;
    logic signed [ACC_W-1:0]   base;
    logic signed [ACC_W:0]     sum;

    // Per-lane ternary select; -x is formed one bit wider so -(-2^(ACT_W-1)) is exact.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [ACT_W:0] xe;
        logic [1:0]     code;
        assign xe      = {bus.act_rdata[i*ACT_W + ACT_W-1], bus.act_rdata[i*ACT_W +: ACT_W]};
        assign code    = bus.w_rdata[2*i +: 2];
        assign prod[i] = (code == 2'b01) ? xe : (code == 2'b11) ? -xe : '0;
        assign lerr[i] = (code == 2'b10);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            r_q        <= '0;
            c_q        <= '0;
            acc_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_first_q <= 1'b0;
            sat_q      <= 1'b0;
            err_q      <= 1'b0;
            row_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            c_q        <= c_d;
            acc_q      <= acc_d;
            rd_vld_q   <= issue;
            rd_first_q <= issue && (c_q == '0);
            sat_q      <= sat_d;
            err_q      <= err_d;
            row_sat_q  <= row_sat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d = S_ISSUE;
                r_d     = '0;
                c_d     = '0;
            end
            S_ISSUE: if (c_q == CW'(CH - 1)) begin
                state_d = S_DRAIN;
                c_d     = '0;
            end else begin
                c_d = c_q + CW'(1);
            end
            S_DRAIN: state_d = S_OUT;
            S_OUT: if (bus.out_ready) begin
                if (r_q == RW'(ROWS - 1)) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_ISSUE;
                    r_d     = r_q + RW'(1);
                    c_d     = '0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        issue         = (state_q == S_ISSUE);
        bus.busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN) || (state_q == S_OUT);
        bus.done      = (state_q == S_DONE);
        bus.act_rd_en = issue;
        bus.w_rd_en   = issue;
        bus.act_addr  = c_q;
        bus.w_addr    = WAW'(r_q) * WAW'(CH) + WAW'(c_q);
        bus.out_valid = (state_q == S_OUT);
        bus.out_data  = acc_q;
        bus.out_row   = r_q;
        bus.sat_flag  = sat_q;
        bus.code_err  = err_q;
    end

    // Datapath: read data is consumed the cycle after issue; a clamped row stays frozen.
    always_comb begin
        lsum = '0;
        for (int i = 0; i < LANES; i++) lsum = lsum + SUM_W'($signed(prod[i]));
        base      = rd_first_q ? '0 : acc_q;
        sum       = (ACC_W+1)'(base) + (ACC_W+1)'(lsum);
        acc_d     = acc_q;
        sat_d     = sat_q;
        err_d     = err_q;
        row_sat_d = row_sat_q;
        if (state_q == S_IDLE && bus.start) begin
            sat_d = 1'b0;
            err_d = 1'b0;
        end
        if (rd_vld_q) begin
            if (|lerr) err_d = 1'b1;
            if (rd_first_q || !row_sat_q) begin
                if (sum[ACC_W] != sum[ACC_W-1]) begin
                    acc_d     = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
                    sat_d     = 1'b1;
                    row_sat_d = 1'b1;
                end else begin
                    acc_d     = sum[ACC_W-1:0];
                    row_sat_d = 1'b0;
                end
            end
        end
    end
endmodule
